// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: accepts one PC fetch at a time and returns the stored
// 32-bit word after a fixed latency, with flush cancellation and a loadable store.
module instr_fetch_unit #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_instr,
    output logic [31:0]           resp_addr,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic                  valid_d;
    logic [31:0]           instr_d;
    logic [31:0]           raddr_d;
    logic                  err_d;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  fetch_err;

    // Byte offset from the store base; negative offsets wrap to huge values and fail the range test.
    assign offset    = addr_q - BASE_ADDR;
    assign word_idx  = offset[DEPTH_LOG2+1:2];
    assign fetch_err = (addr_q[1:0] != 2'b00) || (offset[31:DEPTH_LOG2+2] != '0);

    // Held low during reset so a waiting PC never sees a ready it cannot use.
    assign req_ready = rst_n && (state_q == IDLE) && !flush;

    // Store write port: no reset, contents survive across resets.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_instr <= '0;
            resp_addr  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            resp_valid <= valid_d;
            resp_instr <= instr_d;
            resp_addr  <= raddr_d;
            resp_err   <= err_d;
        end
    end

    // Next-state and response capture; flush overrides both countdown and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = resp_valid;
        instr_d = resp_instr;
        raddr_d = resp_addr;
        err_d   = resp_err;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = WAIT;
                    addr_d  = req_addr;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Store read sees the pre-edge contents, so a same-edge load is not forwarded.
                    state_d = RESP;
                    valid_d = 1'b1;
                    raddr_d = addr_q;
                    err_d   = fetch_err;
                    instr_d = fetch_err ? 32'h0 : mem[word_idx];
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule
